sprite_blitter: RTL

Writer side of the sprite framebuffer path. On a request it copies one APPLE_W x APPLE_H sprite from the sprite ROM into the frame buffer at a signed screen position, for the VGA scan-out logic to read later. Pixels equal to the transparency key and pixels outside the screen are skipped. It sits between game logic (the request source) and the frame-buffer RAM write port.

---
 rtl/sprite_blitter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// Copies one APPLE_W x APPLE_H sprite from the sprite ROM into the frame buffer at a
// signed screen position, skipping transparent and off-screen pixels.
module sprite_blitter #(
    parameter int          SCREEN_W    = 800,
    parameter int          SCREEN_H    = 600,
    parameter int          APPLE_W     = 22,
    parameter int          APPLE_H     = 22,
    parameter int          ROM_LAT     = 1,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_x,
    input  logic [11:0] req_y,
    output logic [8:0]  rom_addr,
    input  logic [11:0] rom_data,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [11:0] fb_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NPIX = APPLE_W * APPLE_H;
    localparam int          CW   = $clog2(APPLE_W);
    localparam int          RW   = $clog2(APPLE_H);
    localparam int          DW   = $clog2(ROM_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DW-1:0]     drain_cnt;
    logic signed [11:0] x_org;
    logic signed [11:0] y_org;

    logic [CW-1:0]      pipe_c [ROM_LAT];
    logic [RW-1:0]      pipe_r [ROM_LAT];
    logic [ROM_LAT-1:0] pipe_v;

    logic               accept;
    logic signed [11:0] px;
    logic signed [11:0] py;
    logic               in_bounds;
    logic               wr;
    logic [18:0]        lin_addr;

    assign req_ready = (state == S_IDLE) || done;
    assign busy      = (state != S_IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            x_org     <= '0;
            y_org     <= '0;
            rom_addr  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_READ;
                        x_org    <= req_x;
                        y_org    <= req_y;
                        rom_addr <= '0;
                        col      <= '0;
                        row      <= '0;
                    end
                end
                S_READ: begin
                    if (rom_addr == 9'(NPIX - 1)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        rom_addr <= rom_addr + 9'd1;
                        if (col == CW'(APPLE_W - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last ROM read plus the write register must flush before done.
                    if (drain_cnt == DW'(ROM_LAT)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pixel coordinates travel alongside the ROM read so they line up with rom_data.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                pipe_c[i] <= '0;
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_c[0] <= col;
            pipe_r[0] <= row;
            pipe_v[0] <= (state == S_READ);
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                pipe_c[i] <= pipe_c[i-1];
                pipe_r[i] <= pipe_r[i-1];
                pipe_v[i] <= pipe_v[i-1];
            end
        end
    end

    always_comb begin
        px        = x_org + $signed(12'(pipe_c[ROM_LAT-1]));
        py        = y_org + $signed(12'(pipe_r[ROM_LAT-1]));
        in_bounds = !px[11] && !py[11]
                    && ($unsigned(px) < 12'(SCREEN_W))
                    && ($unsigned(py) < 12'(SCREEN_H));
        wr        = pipe_v[ROM_LAT-1] && (rom_data != TRANSPARENT) && in_bounds;
        lin_addr  = 19'($unsigned(py)) * 19'(SCREEN_W) + 19'($unsigned(px));
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we <= wr;
            if (wr) begin
                fb_addr <= lin_addr;
                fb_data <= rom_data;
            end
        end
    end

endmodule
